tx_time_gate: RTL and testbench

- Parametrised successor of the single-shot TX pressure comparator.
- Holds a queue of scheduled TX timestamps written by the driver and releases TX pressure, one frame per entry, once the free-running counter reaches each head timestamp.
- Detects frames whose schedule has already passed and counts them.
- Sits between the AXI-lite register file and the TX DMA/datapath throttle in the tx_timing IP.

---
 rtl/tx_timing_defs_pkg.sv | 21 ++
 rtl/tx_ts_fifo.sv | 57 +++++
 rtl/tx_time_gate.sv | 161 ++++++++++++++++
 tb/tb_tx_time_gate.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_timing_defs_pkg.sv
// Shared definitions for the tx_timing gate: FSM encoding, counter widths.
// Optional build macro TX_TIMING_DROP_LATE_EN is consumed by tx_time_gate.
package tx_timing_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELEASE,
    ST_BYPASS
  } gate_state_t;

  localparam int LATE_CNT_W = 32;
  localparam int TS_W_DEF   = 64;

  function automatic logic [LATE_CNT_W-1:0] sat_inc(
    input logic [LATE_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tx_ts_fifo.sv
// First-word-fall-through timestamp queue with a peek at the entry behind
// the head, so the gate can keep pressure released across back-to-back frames.
module tx_ts_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [W-1:0]  head_next,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot this cycle, so a full queue can still take a write
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      level <= level + LW'(do_push) - LW'(do_pop);
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_nxt];

endmodule

// File: rtl/tx_time_gate.sv
// Scheduled TX pressure release gate over a queue of timestamps.
// Build macro TX_TIMING_DROP_LATE_EN: late heads are discarded, not sent.
module tx_time_gate
  import tx_timing_defs_pkg::*;
#(
  parameter  int          TS_WIDTH    = TS_W_DEF,
  parameter  int          DEPTH       = 8,
  parameter  int unsigned LATE_MARGIN = 0,
  localparam int          LW          = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [TS_WIDTH-1:0]   COUNTER_TS,
  input  logic                  ENABLE,
  input  logic [TS_WIDTH-1:0]   SCHED_TS,
  input  logic                  SCHED_VALID,
  output logic                  SCHED_READY,
  input  logic                  FRAME_DONE,
  output logic                  EN_OUT,
  output logic                  PR_OUT,
  output logic                  LATE_PULSE,
  output logic [LATE_CNT_W-1:0] LATE_COUNT,
  output logic [LW-1:0]         LEVEL,
  output logic                  OVERFLOW
);

  localparam logic [TS_WIDTH:0] MARGIN = (TS_WIDTH+1)'(LATE_MARGIN);

  gate_state_t         state;
  logic                first_q;
  logic [TS_WIDTH-1:0] head;
  logic [TS_WIDTH-1:0] head_next;
  logic [LW-1:0]       level;
  logic                full;
  logic                empty;
  logic                pop;
  logic                due;
  logic                due_next;
  logic                late;
  logic                late_hit;
  logic                rel_done;
  logic                remain;
  logic                hold_next;

  tx_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_WIDTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (SCHED_VALID),
    .pop       (pop),
    .din       (SCHED_TS),
    .head      (head),
    .head_next (head_next),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (OVERFLOW)
  );

  assign due      = (COUNTER_TS >= head);
  assign due_next = (COUNTER_TS >= head_next);
  assign late     = ({1'b0, COUNTER_TS} > ({1'b0, head} + MARGIN));
  assign late_hit = ~ENABLE & (state == ST_WAIT) & first_q & late;
  assign rel_done = ~ENABLE & (state == ST_RELEASE) & FRAME_DONE;
  assign remain   = (level > LW'(1));

`ifdef TX_TIMING_DROP_LATE_EN
  logic late_next;
  assign late_next = ({1'b0, COUNTER_TS} > ({1'b0, head_next} + MARGIN));
  assign hold_next = due_next & ~late_next;
  assign pop       = rel_done | late_hit;
`else
  assign hold_next = due_next;
  assign pop       = rel_done;
`endif

  assign SCHED_READY = ~full;
  assign LEVEL       = level;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= ST_IDLE;
      first_q    <= 1'b0;
      EN_OUT     <= 1'b1;
      PR_OUT     <= 1'b1;
      LATE_PULSE <= 1'b0;
      LATE_COUNT <= '0;
    end else begin
      LATE_PULSE <= 1'b0;
      if (ENABLE) begin
        state  <= ST_BYPASS;
        EN_OUT <= 1'b1;
        PR_OUT <= 1'b1;
      end else begin
        unique case (state)
          ST_BYPASS: begin
            state  <= ST_IDLE;
            EN_OUT <= 1'b0;
            PR_OUT <= 1'b0;
          end
          ST_IDLE: begin
            PR_OUT <= 1'b0;
            if (!empty) begin
              state   <= ST_WAIT;
              first_q <= 1'b1;
              EN_OUT  <= 1'b1;
            end else begin
              EN_OUT <= 1'b0;
            end
          end
          ST_WAIT: begin
            first_q <= 1'b0;
            EN_OUT  <= 1'b1;
            if (late_hit) begin
              LATE_PULSE <= 1'b1;
              LATE_COUNT <= sat_inc(LATE_COUNT);
`ifdef TX_TIMING_DROP_LATE_EN
              PR_OUT <= 1'b0;
              if (remain) begin
                first_q <= 1'b1;
              end else begin
                state  <= ST_IDLE;
                EN_OUT <= 1'b0;
              end
`else
              state  <= ST_RELEASE;
              PR_OUT <= 1'b1;
`endif
            end else if (due) begin
              state  <= ST_RELEASE;
              PR_OUT <= 1'b1;
            end else begin
              PR_OUT <= 1'b0;
            end
          end
          ST_RELEASE: begin
            if (FRAME_DONE) begin
              if (remain) begin
                state   <= ST_WAIT;
                first_q <= 1'b1;
                EN_OUT  <= 1'b1;
                PR_OUT  <= hold_next;
              end else begin
                state  <= ST_IDLE;
                EN_OUT <= 1'b0;
                PR_OUT <= 1'b0;
              end
            end else begin
              EN_OUT <= 1'b1;
              PR_OUT <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_time_gate.sv
// Scoreboard bench for tx_time_gate: release times and late events are
// queued by the stimulus and checked by an independent monitor.
module tb_tx_time_gate;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] cnt = '0;
  logic        ena = 1'b1;
  logic [63:0] sts = '0;
  logic        sv = 1'b0;
  logic        srdy;
  logic        fd = 1'b0;
  logic        en_o;
  logic        pr;
  logic        late_pulse;
  logic [31:0] late_cnt;
  logic [3:0]  level;
  logic        ovf;

  int n_tests = 0;
  int n_fail = 0;
  int late_seen = 0;
  bit run = 1'b0;
  bit mon_en = 1'b0;
  bit pr_prev = 1'b1;

  logic [63:0] exp_rel[$];
  logic [31:0] exp_late[$];

  tx_time_gate #(
    .TS_WIDTH    (64),
    .DEPTH       (8),
    .LATE_MARGIN (4)
  ) dut (
    .CLK         (clk),
    .RESETN      (rstn),
    .COUNTER_TS  (cnt),
    .ENABLE      (ena),
    .SCHED_TS    (sts),
    .SCHED_VALID (sv),
    .SCHED_READY (srdy),
    .FRAME_DONE  (fd),
    .EN_OUT      (en_o),
    .PR_OUT      (pr),
    .LATE_PULSE  (late_pulse),
    .LATE_COUNT  (late_cnt),
    .LEVEL       (level),
    .OVERFLOW    (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (run) cnt = cnt + 64'd1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_ts(input logic [63:0] v);
    sv = 1'b1;
    sts = v;
    tick();
    sv = 1'b0;
  endtask

  task automatic frame_done();
    fd = 1'b1;
    tick();
    fd = 1'b0;
  endtask

  task automatic wait_pr(input int lim);
    int k = 0;
    while (!pr && k < lim) begin
      tick();
      k++;
    end
    chk("pr_wait", {63'd0, pr}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en && !ena && pr && !pr_prev) begin
      n_tests++;
      if (exp_rel.size() == 0) begin
        n_fail++;
        $display("FAIL release_unexpected: got counter %0d expected none", cnt);
      end else begin
        logic [63:0] e;
        e = exp_rel.pop_front();
        if (cnt !== e) begin
          n_fail++;
          $display("FAIL release_time: got %0d expected %0d", cnt, e);
        end
      end
    end
    if (late_pulse) begin
      late_seen++;
      n_tests++;
      if (exp_late.size() == 0) begin
        n_fail++;
        $display("FAIL late_unexpected: got count %0d expected none", late_cnt);
      end else begin
        logic [31:0] e;
        e = exp_late.pop_front();
        if (late_cnt !== e) begin
          n_fail++;
          $display("FAIL late_count: got %0d expected %0d", late_cnt, e);
        end
      end
    end
    pr_prev = pr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_en", {63'd0, en_o}, 64'd1);
    chk("rst_pr", {63'd0, pr}, 64'd1);
    chk("rst_level", {60'd0, level}, 64'd0);
    chk("rst_ready", {63'd0, srdy}, 64'd1);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_late", {32'd0, late_cnt}, 64'd0);
    rstn = 1'b1;

    // Bypass: queue fills, FRAME_DONE ignored
    ena = 1'b1;
    tick();
    tick();
    sv = 1'b1;
    fd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sts = 64'(100 + i);
      tick();
    end
    sv = 1'b0;
    fd = 1'b0;
    tick();
    chk("byp_level", {60'd0, level}, 64'd8);
    chk("byp_ready", {63'd0, srdy}, 64'd0);
    chk("byp_ovf", {63'd0, ovf}, 64'd1);
    chk("byp_pr", {63'd0, pr}, 64'd1);
    chk("byp_en", {63'd0, en_o}, 64'd1);

    // Single on-time frame
    ena = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("idle_pr", {63'd0, pr}, 64'd0);
    chk("idle_en", {63'd0, en_o}, 64'd0);
    mon_en = 1'b1;
    cnt = 64'd990;
    run = 1'b1;
    exp_rel.push_back(64'd1001);
    push_ts(64'd1000);
    wait_pr(40);
    repeat (2) tick();
    frame_done();
    chk("t2_pr_drop", {63'd0, pr}, 64'd0);
    chk("t2_level", {60'd0, level}, 64'd0);

    // Three scheduled frames
    cnt = 64'd400;
    exp_rel.push_back(64'd501);
    exp_rel.push_back(64'd601);
    exp_rel.push_back(64'd701);
    push_ts(64'd500);
    push_ts(64'd600);
    push_ts(64'd700);
    for (int i = 0; i < 3; i++) begin
      wait_pr(300);
      repeat (5) tick();
      frame_done();
      chk("t3_pr_drop", {63'd0, pr}, 64'd0);
    end
    chk("t3_late", {32'd0, late_cnt}, 64'd0);
    chk("t3_level", {60'd0, level}, 64'd0);

    // Late entry
    run = 1'b0;
    cnt = 64'd2000;
    exp_late.push_back(32'd1);
`ifndef TX_TIMING_DROP_LATE_EN
    exp_rel.push_back(64'd2000);
`endif
    push_ts(64'd1990);
`ifndef TX_TIMING_DROP_LATE_EN
    wait_pr(20);
    repeat (2) tick();
    frame_done();
`else
    repeat (6) tick();
`endif
    tick();
    chk("t4_late", {32'd0, late_cnt}, 64'd1);
    chk("t4_level", {60'd0, level}, 64'd0);
    chk("t4_pr", {63'd0, pr}, 64'd0);
    chk("t4_pulses", 64'(late_seen), 64'd1);

    // Fill in scheduled mode, overflow, push+pop while full
    cnt = 64'd100;
    exp_rel.push_back(64'd100);
    sv = 1'b1;
    sts = 64'd100;
    repeat (8) tick();
    sv = 1'b0;
    chk("t5_level8", {60'd0, level}, 64'd8);
    chk("t5_ready", {63'd0, srdy}, 64'd0);
    chk("t5_ovf_pre", {63'd0, ovf}, 64'd0);
    push_ts(64'd100);
    chk("t5_ovf", {63'd0, ovf}, 64'd1);
    chk("t5_level_ovf", {60'd0, level}, 64'd8);
    chk("t5_pr", {63'd0, pr}, 64'd1);
    sv = 1'b1;
    fd = 1'b1;
    tick();
    sv = 1'b0;
    fd = 1'b0;
    chk("t5_pushpop", {60'd0, level}, 64'd8);
    tick();

    // Drain to 3 with pressure held, then reset mid-frame
    for (int i = 0; i < 5; i++) begin
      frame_done();
      tick();
      tick();
    end
    chk("t6_level3", {60'd0, level}, 64'd3);
    chk("t6_pr_held", {63'd0, pr}, 64'd1);
    mon_en = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t6_level", {60'd0, level}, 64'd0);
    chk("t6_pr", {63'd0, pr}, 64'd1);
    chk("t6_en", {63'd0, en_o}, 64'd1);
    chk("t6_late", {32'd0, late_cnt}, 64'd0);
    chk("t6_ovf", {63'd0, ovf}, 64'd0);
    chk("t6_ready", {63'd0, srdy}, 64'd1);

    tick();
    chk("sb_rel_left", 64'(exp_rel.size()), 64'd0);
    chk("sb_late_left", 64'(exp_late.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
